// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline issue controller: default widths, the
// instruction bundle, scoreboard entries and the requester identifier.
package pipe_ctrl_pkg;

    localparam int unsigned DEF_REG_AW = 4;
    localparam int unsigned DEF_FUNC_W = 4;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef struct packed {
        logic [DEF_REG_AW-1:0] rs1;
        logic [DEF_REG_AW-1:0] rs2;
        logic [DEF_REG_AW-1:0] rd;
        logic [DEF_FUNC_W-1:0] func;
        logic [DEF_ADDR_W-1:0] addr;
    } instr_t;

    typedef struct packed {
        logic                  v;
        logic [DEF_REG_AW-1:0] rd;
    } sb_entry_t;

    typedef enum logic {
        SRC_REQ0 = 1'b0,
        SRC_REQ1 = 1'b1
    } src_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == '1) ? c : c + 16'd1;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// In-flight destination tracker: PIPE_DEPTH-deep shift register of {v, rd}
// plus the rs1/rs2 read-after-write comparators for both requesters.
module issue_scoreboard #(
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push_v,
    input  logic [pipe_ctrl_pkg::DEF_REG_AW-1:0] push_rd,
    input  logic [pipe_ctrl_pkg::DEF_REG_AW-1:0] req0_rs1,
    input  logic [pipe_ctrl_pkg::DEF_REG_AW-1:0] req0_rs2,
    input  logic [pipe_ctrl_pkg::DEF_REG_AW-1:0] req1_rs1,
    input  logic [pipe_ctrl_pkg::DEF_REG_AW-1:0] req1_rs2,
    output logic                                hazard0,
    output logic                                hazard1
);
    import pipe_ctrl_pkg::*;

    sb_entry_t sb [PIPE_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[0] <= '{v: push_v, rd: push_rd};
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    always_comb begin
        hazard0 = 1'b0;
        hazard1 = 1'b0;
        for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            if (sb[k].v) begin
                hazard0 = hazard0 | (sb[k].rd == req0_rs1) | (sb[k].rd == req0_rs2);
                hazard1 = hazard1 | (sb[k].rd == req1_rs1) | (sb[k].rd == req1_rs2);
            end
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Two-requester round-robin issue controller with RAW bubble insertion.
// Optional statistics counters are built when ISSUE_STATS_EN is defined.
module pipe_issue_ctrl #(
    parameter int unsigned REG_AW     = pipe_ctrl_pkg::DEF_REG_AW,
    parameter int unsigned FUNC_W     = pipe_ctrl_pkg::DEF_FUNC_W,
    parameter int unsigned ADDR_W     = pipe_ctrl_pkg::DEF_ADDR_W,
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              halt,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_AW-1:0] req0_rs1,
    input  logic [REG_AW-1:0] req0_rs2,
    input  logic [REG_AW-1:0] req0_rd,
    input  logic [FUNC_W-1:0] req0_func,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_AW-1:0] req1_rs1,
    input  logic [REG_AW-1:0] req1_rs2,
    input  logic [REG_AW-1:0] req1_rd,
    input  logic [FUNC_W-1:0] req1_func,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              issue_valid,
    output logic [REG_AW-1:0] issue_rs1,
    output logic [REG_AW-1:0] issue_rs2,
    output logic [REG_AW-1:0] issue_rd,
    output logic [FUNC_W-1:0] issue_func,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              issue_src,
    output logic [15:0]       issued_cnt,
    output logic [15:0]       bubble_cnt
);
    import pipe_ctrl_pkg::*;

    instr_t req0_instr, req1_instr, grant_instr, issue_q;
    src_t   last, issue_src_q;
    logic   hazard0, hazard1;
    logic   elig0, elig1, grant0, grant1, grant;

    assign req0_instr = '{rs1: req0_rs1, rs2: req0_rs2, rd: req0_rd, func: req0_func, addr: req0_addr};
    assign req1_instr = '{rs1: req1_rs1, rs2: req1_rs2, rd: req1_rd, func: req1_func, addr: req1_addr};

    issue_scoreboard #(
        .PIPE_DEPTH(PIPE_DEPTH)
    ) u_sb (
        .clk     (CLK),
        .rst_n   (RST_N),
        .push_v  (grant),
        .push_rd (grant_instr.rd),
        .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2),
        .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2),
        .hazard0 (hazard0),
        .hazard1 (hazard1)
    );

    // The requester other than `last` wins a tie; a lone eligible requester always wins.
    always_comb begin
        elig0       = RST_N & req0_valid & ~hazard0 & ~halt;
        elig1       = RST_N & req1_valid & ~hazard1 & ~halt;
        grant0      = elig0 & (~elig1 | (last == SRC_REQ1));
        grant1      = elig1 & ~grant0;
        grant       = grant0 | grant1;
        grant_instr = grant1 ? req1_instr : req0_instr;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            issue_valid <= 1'b0;
            issue_q     <= '0;
            issue_src_q <= SRC_REQ0;
            last        <= SRC_REQ1;
        end else begin
            issue_valid <= grant;
            if (grant) begin
                issue_q     <= grant_instr;
                issue_src_q <= grant1 ? SRC_REQ1 : SRC_REQ0;
                last        <= grant1 ? SRC_REQ1 : SRC_REQ0;
            end
        end
    end

    assign issue_rs1  = issue_q.rs1;
    assign issue_rs2  = issue_q.rs2;
    assign issue_rd   = issue_q.rd;
    assign issue_func = issue_q.func;
    assign issue_addr = issue_q.addr;
    assign issue_src  = issue_src_q;

`ifdef ISSUE_STATS_EN
    logic [15:0] issued_q, bubble_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            issued_q <= '0;
            bubble_q <= '0;
        end else if (grant) begin
            issued_q <= sat_inc(issued_q);
        end else if (req0_valid | req1_valid) begin
            bubble_q <= sat_inc(bubble_q);
        end
    end

    assign issued_cnt = issued_q;
    assign bubble_cnt = bubble_q;
`else
    assign issued_cnt = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Scoreboard bench for pipe_issue_ctrl: directed scenarios plus random
// traffic, checked against a register-busy-until reference model.
module tb_pipe_issue_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int DEPTH = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        halt = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_rs1 = '0, req0_rs2 = '0, req0_rd = '0, req0_func = '0;
    logic [3:0]  req1_rs1 = '0, req1_rs2 = '0, req1_rd = '0, req1_func = '0;
    logic [7:0]  req0_addr = '0, req1_addr = '0;
    logic        issue_valid, issue_src;
    logic [3:0]  issue_rs1, issue_rs2, issue_rd, issue_func;
    logic [7:0]  issue_addr;
    logic [15:0] issued_cnt, bubble_cnt;

    pipe_issue_ctrl #(.PIPE_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .halt(halt),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd(req0_rd),
        .req0_func(req0_func), .req0_addr(req0_addr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd(req1_rd),
        .req1_func(req1_func), .req1_addr(req1_addr),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_func(issue_func), .issue_addr(issue_addr),
        .issue_src(issue_src), .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct { instr_t b; logic src; } exp_t;

    exp_t   expq[$];
    instr_t rq0[$], rq1[$];
    int     busy_until [16];
    logic   m_last;
    instr_t m_hold;
    int     edge_no = 0, m_issued = 0, m_bubble = 0;
    bit     pres0 = 0, pres1 = 0, gaps = 0;
    int     g0_edges[$], g1_edges[$], src_log[$];
    int     tests = 0, fails = 0;
    int     e, base_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic instr_t mk(input int rs1, input int rs2, input int rd, input int func, input int addr);
        instr_t t;
        t.rs1 = 4'(rs1); t.rs2 = 4'(rs2); t.rd = 4'(rd);
        t.func = 4'(func); t.addr = 8'(addr);
        return t;
    endfunction

    function automatic instr_t rnd();
        return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 255));
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // A source register is unreadable at every edge up to busy_until.
    function automatic bit blocked(input instr_t i);
        return (busy_until[i.rs1] >= edge_no) || (busy_until[i.rs2] >= edge_no);
    endfunction

    task automatic model_reset();
        foreach (busy_until[r]) busy_until[r] = -100;
        m_last = 1'b1;
        m_hold = '0;
        m_issued = 0;
        m_bubble = 0;
        expq.delete();
    endtask

    task automatic drive_inputs();
        pres0 = (rq0.size() > 0) && (pres0 || !gaps || $urandom_range(0, 3) != 0);
        pres1 = (rq1.size() > 0) && (pres1 || !gaps || $urandom_range(0, 3) != 0);
        req0_valid = pres0;
        req1_valid = pres1;
        if (rq0.size() > 0) {req0_rs1, req0_rs2, req0_rd, req0_func, req0_addr} = rq0[0];
        if (rq1.size() > 0) {req1_rs1, req1_rs2, req1_rd, req1_func, req1_addr} = rq1[0];
    endtask

    task automatic cycle();
        bit e0, e1, p0, p1;
        instr_t w;
        #1;
        if (!RST_N) begin
            check("ready0_in_reset", 32'(req0_ready), 32'(0));
            check("ready1_in_reset", 32'(req1_ready), 32'(0));
            @(posedge CLK);
            model_reset();
        end else begin
            e0 = 0; e1 = 0;
            if (req0_valid && !halt) e0 = !blocked(rq0[0]);
            if (req1_valid && !halt) e1 = !blocked(rq1[0]);
            if (e0 && e1) begin
                p0 = (m_last == 1'b1);
                p1 = !p0;
            end else begin
                p0 = e0;
                p1 = e1;
            end
            check("req0_ready", 32'(req0_ready), 32'(p0));
            check("req1_ready", 32'(req1_ready), 32'(p1));
            if (req0_ready === 1'b1) begin g0_edges.push_back(edge_no); src_log.push_back(0); end
            if (req1_ready === 1'b1) begin g1_edges.push_back(edge_no); src_log.push_back(1); end
            if (p0) expq.push_back('{rq0[0], 1'b0});
            if (p1) expq.push_back('{rq1[0], 1'b1});
            @(posedge CLK);
            if (p0 || p1) begin
                w = p0 ? rq0.pop_front() : rq1.pop_front();
                busy_until[w.rd] = edge_no + DEPTH;
                m_hold = w;
                m_last = p1;
                m_issued++;
                if (p0) pres0 = 0; else pres1 = 0;
            end else if (req0_valid || req1_valid) begin
                m_bubble++;
            end
        end
        edge_no++;
        @(negedge CLK);
        #1;
        drive_inputs();
    endtask

    task automatic check_counters(input string tag);
`ifdef ISSUE_STATS_EN
        check({tag, "_issued_cnt"}, 32'(issued_cnt), 32'(m_issued));
        check({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(m_bubble));
`else
        check({tag, "_issued_cnt"}, 32'(issued_cnt), 32'(0));
        check({tag, "_bubble_cnt"}, 32'(bubble_cnt), 32'(0));
`endif
    endtask

    task automatic drain();
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0) && n < 200) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(rq0.size() + rq1.size()), 32'(0));
        repeat (DEPTH + 1) cycle();
        g0_edges.delete(); g1_edges.delete(); src_log.delete();
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0; drive_inputs(); cycle();
        RST_N = 1'b1; drive_inputs();
    endtask

    // Monitor: pops the expected bundle whenever the DUT presents an issue.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            check("issue_valid", 32'(issue_valid), 32'(expq.size() != 0));
            if (issue_valid === 1'b1 && expq.size() != 0) begin
                x = expq.pop_front();
                check("issue_bundle", 32'({issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr}), 32'(x.b));
                check("issue_src", 32'(issue_src), 32'(x.src));
            end else if (issue_valid !== 1'b1) begin
                check("held_bundle", 32'({issue_rs1, issue_rs2, issue_rd, issue_func, issue_addr}), 32'(m_hold));
            end
            expq.delete();
        end
    end

    initial begin
        model_reset();

        // Reset held for 3 edges with both requesters valid.
        rq0.push_back(mk(3, 5, 10, 10, 10));
        rq1.push_back(mk(1, 2, 11, 3, 4));
        drive_inputs();
        repeat (3) begin
            cycle();
            check("reset_issue_valid", 32'(issue_valid), 32'(0));
        end
        rq1.delete(); pres1 = 0; RST_N = 1'b1; drive_inputs();
        e = edge_no;
        cycle();
        check("post_reset_grant", 32'(at(g0_edges, 0)), 32'(e));
        drain();

        // RAW stall.
        base_b = m_bubble;
        rq0.push_back(mk(0, 0, 1, 2, 20));
        rq0.push_back(mk(1, 2, 3, 4, 21));
        drive_inputs();
        repeat (7) cycle();
        check("raw_gap", 32'(at(g0_edges, 1) - at(g0_edges, 0)), 32'(DEPTH + 1));
`ifdef ISSUE_STATS_EN
        check("raw_bubble_cnt", 32'(bubble_cnt), 32'(base_b + DEPTH));
`endif
        check_counters("raw");
        drain();

        // Round-robin from a fresh reset.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            rq0.push_back(mk(0, 0, 8 + i, i, 30 + i));
            rq1.push_back(mk(0, 0, 11 + i, 4 + i, 40 + i));
        end
        drive_inputs();
        repeat (6) cycle();
        for (int i = 0; i < 6; i++) check("rr_src_order", 32'(at(src_log, i)), 32'(i % 2));
`ifdef ISSUE_STATS_EN
        check("rr_issued_cnt", 32'(issued_cnt), 32'(6));
`endif
        drain();

        // Overtake: req1 passes a stalled req0.
        rq0.push_back(mk(0, 0, 4, 1, 50));
        rq0.push_back(mk(4, 0, 6, 2, 51));
        drive_inputs();
        e = edge_no;
        cycle();
        rq1.push_back(mk(14, 13, 5, 3, 52));
        drive_inputs();
        repeat (5) cycle();
        check("overtake_req1_edge", 32'(at(g1_edges, 0)), 32'(e + 1));
        check("overtake_req0_edge", 32'(at(g0_edges, 1)), 32'(e + DEPTH + 1));
        drain();

        // halt for two cycles while an otherwise-eligible request waits.
        base_b = m_bubble;
        rq0.push_back(mk(0, 0, 9, 5, 60));
        rq0.push_back(mk(9, 0, 2, 6, 61));
        drive_inputs();
        e = edge_no;
        cycle();
        cycle();
        halt = 1'b1;
        rq1.push_back(mk(0, 0, 12, 7, 62));
        drive_inputs();
        repeat (2) begin
            #1;
            check("halt_ready", 32'(req0_ready | req1_ready), 32'(0));
            cycle();
        end
        halt = 1'b0; drive_inputs();
        repeat (3) cycle();
        check("halt_release_req1", 32'(at(g1_edges, 0)), 32'(e + 4));
        check("halt_release_req0", 32'(at(g0_edges, 1)), 32'(e + 5));
`ifdef ISSUE_STATS_EN
        check("halt_bubble_cnt", 32'(bubble_cnt), 32'(base_b + 3));
`endif
        drain();

        // Reset mid-stream drops the rd=7 dependency.
        rq0.push_back(mk(0, 0, 7, 8, 70));
        drive_inputs();
        cycle();
        pulse_reset();
        rq0.push_back(mk(7, 0, 3, 9, 71));
        drive_inputs();
        e = edge_no;
        cycle();
        check("midreset_grant", 32'(at(g0_edges, 1)), 32'(e));
        drain();
        check_counters("directed");

        // Random traffic with gaps, halts and occasional resets.
        gaps = 1;
        for (int c = 0; c < 600; c++) begin
            while (rq0.size() < 2) rq0.push_back(rnd());
            while (rq1.size() < 2) rq1.push_back(rnd());
            halt  = ($urandom_range(0, 7) == 0);
            RST_N = ($urandom_range(0, 149) != 0);
            drive_inputs();
            cycle();
            if (c % 50 == 49) check_counters("random");
        end
        halt = 1'b0; RST_N = 1'b1; gaps = 0;
        drive_inputs();
        drain();
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
